// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and access-size helpers for the lsu
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RMW_ISSUE,
        RMW_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Unlisted funct3 codes (011/110/111) fall through to a word access.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = SZ_BYTE;
            F3_H, F3_HU: access_size = SZ_HALF;
            default:     access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational load extract/extend and sub-word store merge
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] merged
);

    logic       sext;
    logic [7:0] byte_val;
    logic [15:0] half_val;

    // Lane select: addr_lo picks the byte, addr_lo[1] the half; addr_lo[0] is ignored for halves.
    always_comb begin
        sext       = ~funct3[2];
        byte_val   = word[{addr_lo, 3'b000} +: 8];
        half_val   = word[{addr_lo[1], 4'b0000} +: 16];
        load_value = word;
        merged     = new_data;
        case (access_size(funct3))
            SZ_BYTE: begin
                load_value = {{(DATA_WIDTH-8){sext & byte_val[7]}}, byte_val};
                merged     = word;
                merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_value = {{(DATA_WIDTH-16){sext & half_val[15]}}, half_val};
                merged     = word;
                merged[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_value = word;
                merged     = new_data;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit to mmu with sub-word RMW; optional LSU_MISALIGN_TRAP_EN
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_we,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_w_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_ready
);

    state_t                state;
    state_t                state_next;
    logic [1:0]            addr_lo_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [DATA_WIDTH-1:0] lane_load;
    logic [DATA_WIDTH-1:0] lane_merged;
    logic                  accept;
    logic                  trap;

    assign accept = (state == IDLE) && ex_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign trap       = is_misaligned(ex_funct3, ex_addr[1:0]);
    assign misaligned = misaligned_q;

    // Flag is raised only during the DONE cycle that follows a trapped accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= accept && trap;
        end
    end
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    lsu_byte_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_lane (
        .word       (mem_r_data),
        .new_data   (w_data_q),
        .addr_lo    (addr_lo_q),
        .funct3     (funct3_q),
        .load_value (lane_load),
        .merged     (lane_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and single-cycle mmu request decode.
    always_comb begin
        state_next = state;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (trap) begin
                        state_next = DONE;
                    end else if (ex_we && (access_size(ex_funct3) != SZ_WORD)) begin
                        state_next = RMW_ISSUE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_valid  = 1'b1;
                mem_we     = we_q;
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            RMW_ISSUE: begin
                mem_valid  = 1'b1;
                state_next = RMW_WAIT;
            end
            RMW_WAIT: begin
                if (mem_ready) begin
                    state_next = ISSUE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall = accept || ((state != IDLE) && (state != DONE));

    // Request capture, load result update and RMW merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            w_data_q   <= '0;
            load_data  <= '0;
            mem_addr   <= '0;
            mem_w_data <= '0;
        end else begin
            if (accept) begin
                addr_lo_q <= ex_addr[1:0];
                funct3_q  <= ex_funct3;
                we_q      <= ex_we;
                w_data_q  <= ex_w_data;
                mem_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                if (ex_we) begin
                    mem_w_data <= ex_w_data;
                end
            end
            if ((state == WAIT) && mem_ready && !we_q) begin
                load_data <= lane_load;
            end
            if ((state == RMW_WAIT) && mem_ready) begin
                mem_w_data <= lane_merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu with a cycle-accurate mmu responder
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_w_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    int          nv, nw, ns, nm;
    logic [31:0] raddr, waddr, wdat, ld;
    logic        to;

    always #5 clk = ~clk;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_w_data  (ex_w_data),
        .load_data  (load_data),
        .stall      (stall),
        .misaligned (misaligned),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .mem_ready  (mem_ready)
    );

    // Issues one instruction at a negedge in IDLE and plays mmu: every request is answered
    // lat cycles after its pulse. Returns at the following IDLE negedge.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int lat,
                          output int o_nv, output int o_nw, output int o_ns, output int o_nm,
                          output logic [31:0] o_raddr, output logic [31:0] o_waddr,
                          output logic [31:0] o_wdat, output logic [31:0] o_ld, output logic o_to);
        int   pend;
        logic done;
        o_nv = 0; o_nw = 0; o_ns = 0; o_nm = 0;
        o_raddr = 0; o_waddr = 0; o_wdat = 0; o_ld = 0;
        pend = -1;
        done = 1'b0;
        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_w_data = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) ex_valid = 1'b0;
            mem_ready = 1'b0;
            if (pend == 0) begin
                mem_ready  = 1'b1;
                mem_r_data = rd;
            end
            if (pend >= 0) pend--;
            #1;
            if (stall) o_ns++;
            if (misaligned) o_nm++;
            if (mem_valid) begin
                o_nv++;
                if (mem_we) begin
                    o_nw++;
                    o_waddr = mem_addr;
                    o_wdat  = mem_w_data;
                end else begin
                    o_raddr = mem_addr;
                end
                pend = lat - 1;
            end
            if (c > 0 && !stall) begin
                done = 1'b1;
                o_ld = load_data;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        o_to = !done;
        ex_valid  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0; ex_w_data = 32'h0; mem_r_data = 32'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got=%h exp=%h", load_data, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mem_valid !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_valid_we got=%b%b exp=00", mem_valid, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_w_data !== 32'h0) begin errors++; $display("FAIL reset_mem_addr_data got=%h/%h exp=0/0", mem_addr, mem_w_data); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
        ex_valid = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follows_ex_valid got=%b exp=1", stall); end
        ex_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_lw_hit();
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lw_timeout got=%b exp=0", to); end
        checks++; if (nv !== 1 || nw !== 0) begin errors++; $display("FAIL lw_pulses got=%0d/%0d exp=1/0", nv, nw); end
        checks++; if (raddr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h exp=%h", raddr, 32'h100); end
        checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=%h", ld, 32'hDEADBEEF); end
        checks++; if (ns !== 3) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=3", ns); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
        logic [31:0] adr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
        logic [31:0] wrd [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12347FFF};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h00000000, 32'h00007FFF};
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, f3[i], adr[i], 32'h0, wrd[i], 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
            checks++; if (ld !== exp[i] || to !== 1'b0) begin errors++; $display("FAIL load_extend[%0d] got=%h exp=%h", i, ld, exp[i]); end
            checks++; if (raddr !== 32'h100 || nv !== 1) begin errors++; $display("FAIL load_extend_req[%0d] got=%h/%0d exp=100/1", i, raddr, nv); end
        end
    endtask

    task automatic test_sub_word_store();
        run_op(1'b1, 3'b000, 32'h101, 32'h000000AA, 32'h11223344, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (nv !== 2 || nw !== 1 || to !== 1'b0) begin errors++; $display("FAIL sb_pulses got=%0d/%0d exp=2/1", nv, nw); end
        checks++; if (raddr !== 32'h100 || waddr !== 32'h100) begin errors++; $display("FAIL sb_addr got=%h/%h exp=100/100", raddr, waddr); end
        checks++; if (wdat !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge got=%h exp=%h", wdat, 32'h1122AA44); end
        checks++; if (ns !== 5) begin errors++; $display("FAIL sb_stall_cycles got=%0d exp=5", ns); end
        run_op(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h11223344, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (wdat !== 32'hBEEF3344 || waddr !== 32'h200) begin errors++; $display("FAIL sh_merge got=%h@%h exp=BEEF3344@200", wdat, waddr); end
        checks++; if (ld !== 32'h00007FFF) begin errors++; $display("FAIL sh_load_data_held got=%h exp=%h", ld, 32'h00007FFF); end
    endtask

    task automatic test_sw();
        run_op(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (nv !== 1 || nw !== 1 || to !== 1'b0) begin errors++; $display("FAIL sw_pulses got=%0d/%0d exp=1/1", nv, nw); end
        checks++; if (wdat !== 32'hCAFEF00D || waddr !== 32'h104) begin errors++; $display("FAIL sw_data got=%h@%h exp=CAFEF00D@104", wdat, waddr); end
        checks++; if (ns !== 3) begin errors++; $display("FAIL sw_stall_cycles got=%0d exp=3", ns); end
        checks++; if (ld !== 32'h00007FFF) begin errors++; $display("FAIL sw_load_data_held got=%h exp=%h", ld, 32'h00007FFF); end
    endtask

    task automatic test_miss();
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 7, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (nv !== 1 || to !== 1'b0) begin errors++; $display("FAIL miss_single_issue got=%0d exp=1", nv); end
        checks++; if (ns !== 9) begin errors++; $display("FAIL miss_stall_cycles got=%0d exp=9", ns); end
        checks++; if (ld !== 32'h0BADF00D) begin errors++; $display("FAIL miss_data got=%h exp=%h", ld, 32'h0BADF00D); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 32'h01020304, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (ld !== 32'h01020304 || nv !== 1) begin errors++; $display("FAIL b2b_first got=%h/%0d exp=01020304/1", ld, nv); end
        run_op(1'b0, 3'b100, 32'h12, 32'h0, 32'hA5B6C7D8, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (ld !== 32'h000000B6 || nv !== 1 || raddr !== 32'h10) begin errors++; $display("FAIL b2b_second got=%h/%0d@%h exp=000000B6/1@10", ld, nv, raddr); end
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h500;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1; ex_valid = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_mid_load_data got=%h exp=0", load_data); end
        checks++; if (stall !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_stall_addr got=%b/%h exp=1/0", stall, mem_addr); end
        ex_valid = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall_idle got=%b exp=0", stall); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (ld !== 32'h13579BDF || nv !== 1 || to !== 1'b0) begin errors++; $display("FAIL rst_mid_recover got=%h/%0d exp=13579BDF/1", ld, nv); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h55667788, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (nv !== 0 || to !== 1'b0) begin errors++; $display("FAIL mis_lw_no_request got=%0d exp=0", nv); end
        checks++; if (nm !== 1) begin errors++; $display("FAIL mis_lw_flag_cycles got=%0d exp=1", nm); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL mis_lw_stall_cycles got=%0d exp=1", ns); end
        checks++; if (ld !== 32'h13579BDF) begin errors++; $display("FAIL mis_lw_load_held got=%h exp=%h", ld, 32'h13579BDF); end
        run_op(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (nv !== 0 || nm !== 1 || ns !== 1) begin errors++; $display("FAIL mis_sh got=%0d/%0d/%0d exp=0/1/1", nv, nm, ns); end
        #1;
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_flag_clears got=%b exp=0", misaligned); end
`else
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h55667788, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (ld !== 32'h55667788 || raddr !== 32'h100 || nv !== 1) begin errors++; $display("FAIL align_lw got=%h@%h/%0d exp=55667788@100/1", ld, raddr, nv); end
        checks++; if (nm !== 0 || ns !== 3) begin errors++; $display("FAIL align_lw_flags got=%0d/%0d exp=0/3", nm, ns); end
        run_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h80FF8001, 1, nv, nw, ns, nm, raddr, waddr, wdat, ld, to);
        checks++; if (ld !== 32'hFFFF8001 || nm !== 0) begin errors++; $display("FAIL align_lh got=%h/%0d exp=FFFF8001/0", ld, nm); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw_hit();
        test_load_extend();
        test_sub_word_store();
        test_sw();
        test_miss();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
